// File: rtl/bcd_to_bin_seq_if.sv
// Start/busy/done handshake bundle for bcd_to_bin_seq.
// Handshake: start+bcd_in are taken on any rising edge where busy=0; done pulses one cycle with results, which then hold until the next accepted start.
interface bcd_to_bin_seq_if #(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
);
   logic                  start;
   logic [4*DIGITS-1:0]   bcd_in;
   logic                  busy;
   logic                  done;
   logic [BIN_W-1:0]      bin_out;
   logic                  ovf;
   logic                  err;
   logic [1:0]            fsm_state;

   modport master (
      output start, bcd_in,
      input  busy, done, bin_out, ovf, err, fsm_state
   );

   modport slave (
      input  start, bcd_in,
      output busy, done, bin_out, ovf, err, fsm_state
   );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one result bit per clock.
// Optional input-digit validation enabled by defining BCD2BIN_CHECK_EN.
module bcd_to_bin_seq #(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
) (
   input logic             clk,
   input logic             rst_n,
   bcd_to_bin_seq_if.slave bus
);
   localparam int DW = 4 * DIGITS;
   localparam int CW = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [DW-1:0]       d_q, d_d, d_sh, d_adj;
   logic [BIN_W-1:0]    b_q, b_d, b_sh;
   logic [BIN_W-1:0]    bin_q, bin_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                ovf_q, ovf_d;
   logic                err_q, err_d;
   logic [DW+BIN_W-1:0] shifted;
   logic                bad_digit;

   // One step: {D,B} moves right, then every D nibble >= 8 drops by 3 so D stays BCD of the halved value.
   assign shifted = {d_q, b_q} >> 1;
   assign d_sh    = shifted[DW+BIN_W-1:BIN_W];
   assign b_sh    = shifted[BIN_W-1:0];

   always_comb begin
      d_adj = d_sh;
      for (int i = 0; i < DIGITS; i++) begin
         if (d_sh[4*i+3]) d_adj[4*i +: 4] = d_sh[4*i +: 4] - 4'd3;
      end
   end

`ifdef BCD2BIN_CHECK_EN
   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bus.bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
      end
   end
`else
   assign bad_digit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      d_d     = d_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      bin_d   = bin_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               d_d   = bus.bcd_in;
               b_d   = '0;
               cnt_d = '0;
               ovf_d = 1'b0;
               err_d = 1'b0;
               if (bad_digit) begin
                  bin_d   = '0;
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = CONV;
               end
            end else begin
               state_d = IDLE;
            end
         end
         CONV: begin
            d_d   = d_adj;
            b_d   = b_sh;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(BIN_W - 1)) begin
               bin_d   = b_sh;
               ovf_d   = |d_adj;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         d_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         bin_q   <= '0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

   assign bus.busy      = (state_q == CONV);
   assign bus.done      = (state_q == DONE);
   assign bus.bin_out   = bin_q;
   assign bus.ovf       = ovf_q;
   assign bus.err       = err_q;
   assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: a 3-digit and a 4-digit instance, both 10-bit results.
module tb_bcd_to_bin_seq;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   bcd_to_bin_seq_if #(.DIGITS(3), .BIN_W(10)) b3 ();
   bcd_to_bin_seq_if #(.DIGITS(4), .BIN_W(10)) b4 ();

   bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
   bcd_to_bin_seq #(.DIGITS(4), .BIN_W(10)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic launch3(input logic [11:0] v);
      b3.start  = 1'b1;
      b3.bcd_in = v;
      @(posedge clk); #1;
      b3.start  = 1'b0;
   endtask

   // Waits for done, checking latency, busy duration and results.
   task automatic wait3(input string tag, input int exp_val, input int exp_lat,
                        input logic exp_ovf, input logic exp_err);
      int lat;
      int busy_cnt;
      lat = 0;
      busy_cnt = 0;
      while (!b3.done && lat < 40) begin
         if (b3.busy) busy_cnt++;
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, " latency"}, lat, exp_lat);
      chk({tag, " busy_cycles"}, busy_cnt, exp_lat);
      chk({tag, " busy_at_done"}, b3.busy, 1'b0);
      chk({tag, " bin_out"}, b3.bin_out, exp_val);
      chk({tag, " ovf"}, b3.ovf, exp_ovf);
      chk({tag, " err"}, b3.err, exp_err);
   endtask

   task automatic conv3(input string tag, input logic [11:0] v, input int exp_val,
                        input int exp_lat, input logic exp_ovf, input logic exp_err);
      @(negedge clk);
      launch3(v);
      wait3(tag, exp_val, exp_lat, exp_ovf, exp_err);
   endtask

   task automatic conv4(input string tag, input logic [15:0] v, input int exp_val, input logic exp_ovf);
      int lat;
      @(negedge clk);
      b4.start  = 1'b1;
      b4.bcd_in = v;
      @(posedge clk); #1;
      b4.start  = 1'b0;
      lat = 0;
      while (!b4.done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, " latency"}, lat, 10);
      chk({tag, " bin_out"}, b4.bin_out, exp_val);
      chk({tag, " ovf"}, b4.ovf, exp_ovf);
      chk({tag, " err"}, b4.err, 1'b0);
   endtask

   initial begin
      int seen_done;
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      b3.start  = 1'b0;
      b3.bcd_in = '0;
      b4.start  = 1'b0;
      b4.bcd_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", b3.busy, 1'b0);
      chk("reset done", b3.done, 1'b0);
      chk("reset bin_out", b3.bin_out, 0);
      chk("reset ovf", b3.ovf, 1'b0);
      chk("reset err", b3.err, 1'b0);
      chk("reset state", b3.fsm_state, 2'd0);
      chk("reset4 bin_out", b4.bin_out, 0);
      @(negedge clk);
      rst_n = 1'b1;

      conv3("h227", 12'h227, 227, 10, 1'b0, 1'b0);
      chk("h227 state_done", b3.fsm_state, 2'd2);
      conv3("h999", 12'h999, 999, 10, 1'b0, 1'b0);
      conv3("h000", 12'h000, 0, 10, 1'b0, 1'b0);

      for (int i = 0; i < 1000; i++) begin
         conv3("sweep", {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)}, i, 10, 1'b0, 1'b0);
      end

      conv4("h1500", 16'h1500, 476, 1'b1);
      conv4("h1023", 16'h1023, 1023, 1'b0);
      conv4("h1024", 16'h1024, 0, 1'b1);
      conv4("h9999", 16'h9999, 783, 1'b1);

      // Back-to-back: second start issued during the first done cycle.
      conv3("b2b_first", 12'h045, 45, 10, 1'b0, 1'b0);
      launch3(12'h310);
      wait3("b2b_second", 310, 10, 1'b0, 1'b0);

      // Start pulse one edge into CONV must be ignored.
      @(negedge clk);
      launch3(12'h123);
      b3.start  = 1'b1;
      b3.bcd_in = 12'h999;
      @(posedge clk); #1;
      b3.start  = 1'b0;
      wait3("midconv_start", 123, 9, 1'b0, 1'b0);

      // Reset in the middle of a conversion.
      @(negedge clk);
      launch3(12'h555);
      repeat (4) begin
         @(posedge clk); #1;
      end
      chk("pre_rst busy", b3.busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rst busy", b3.busy, 1'b0);
      chk("rst done", b3.done, 1'b0);
      chk("rst bin_out", b3.bin_out, 0);
      chk("rst ovf", b3.ovf, 1'b0);
      chk("rst err", b3.err, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen_done = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (b3.done) seen_done++;
      end
      chk("rst no_done", seen_done, 0);
      conv3("after_rst", 12'h001, 1, 10, 1'b0, 1'b0);

`ifdef BCD2BIN_CHECK_EN
      conv3("h2A7", 12'h2A7, 0, 1, 1'b0, 1'b1);
`else
      conv3("h2A7", 12'h2A7, 307, 10, 1'b0, 1'b0);
`endif
      conv3("valid_after_bad", 12'h876, 876, 10, 1'b0, 1'b0);

      @(posedge clk); #1;
      chk("idle_after_done", b3.done, 1'b0);
      chk("idle hold bin_out", b3.bin_out, 876);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bcd_to_bin_seq.md
# bcd_to_bin_seq

Parametrised sequential BCD-to-binary converter using the shift-right / subtract-3 (reverse double-dabble) algorithm. It converts a DIGITS-digit packed BCD word into a BIN_W-bit binary value, one bit per clock, under a start/busy/done handshake. It supersedes the fixed 3-digit/10-bit converter, adds overflow detection and optional input-digit validation, and sits between BCD keypad/display datapaths and binary arithmetic units.

## Interface
- DIGITS, 3, number of BCD digits at the input (1..8)
- BIN_W, 10, binary result width and iteration count (1..32)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  conversion request, sampled on clk when the block is not busy
- bcd_in  in  4*DIGITS  packed BCD; digit 0 in [3:0], most significant digit in the top nibble; sampled with an accepted start
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse: result valid
- bin_out  out  BIN_W  binary result; held from done until the next accepted start
- ovf  out  1  BCD value ≥ 2^BIN_W; bin_out then holds value mod 2^BIN_W; valid with done and held
- err  out  1  invalid input digit; see Configuration; held like ovf

## Operation
- States: IDLE, CONV, DONE.
- IDLE or DONE, start=1: load digit register D (4*DIGITS bits) from bcd_in; clear shift register B (BIN_W bits); clear iteration counter cnt (width $clog2(BIN_W+1)); clear ovf and err; go to CONV.
- CONV, each edge:
  - Shift {D,B} right by 1: B[BIN_W-1] takes D[0], and D's MSB is filled with 0.
  - After the shift, subtract 3 from every 4-bit nibble of D that is ≥ 8. This is 4-bit arithmetic with no borrow across nibbles.
  - Increment cnt. If the pre-increment value was BIN_W-1, go to DONE.
- Entering DONE: bin_out ← B (the shifted value); ovf ← |D (residual non-zero); done=1 for exactly that cycle.
- DONE with no start: return to IDLE next edge. Outputs hold.
- start while in CONV: ignored. bcd_in is not re-sampled.
- bin_out, ovf and err change only on entering DONE, on an accepted start (ovf/err clear, bin_out holds until the next DONE), or on reset.

## Timing
- Reset (async assert, sync-safe release): state IDLE, busy=0, done=0, bin_out=0, ovf=0, err=0, D=0, B=0, cnt=0.
- Start accepted at edge k:
  - busy=1 from after edge k until after edge k+BIN_W.
  - done=1 and the result is visible during the cycle after edge k+BIN_W. Latency is BIN_W clocks.
- busy and done are never high together.
- Back-to-back: a start in the done cycle is accepted. The next done follows BIN_W+1 edges after the previous start. Throughput is one conversion per BIN_W+1 clocks.
- rst_n asserted mid-conversion: immediate return to reset values. The partial result is discarded and done does not pulse.
- BIN_W=1: a single CONV cycle.

## Configuration
- BCD2BIN_CHECK_EN defined:
  - An accepted start with any nibble of bcd_in > 9 skips CONV and goes to DONE on the next edge.
  - In that case err=1, bin_out=0, ovf=0, and done pulses (latency 1).
  - Valid input gives err=0 and normal timing.
- BCD2BIN_CHECK_EN undefined:
  - No check is performed; err is tied to 0.
  - Invalid digits are converted through the normal algorithm. The result is deterministic but meaningless.

## Test plan
- DIGITS=3, BIN_W=10, bcd_in=12'h227, start pulse → done exactly 10 clocks later, bin_out=10'd227, ovf=0, err=0; busy high for those 10 cycles.
- Same config, sweep 000..999 → bin_out equals the decimal value every time, ovf=0; 12'h999 → 10'd999 (0x3E7).
- DIGITS=4, BIN_W=10, bcd_in=16'h1500 → done after 10 clocks, ovf=1, bin_out=1500 mod 1024=10'd476; 16'h1023 → bin_out=10'd1023, ovf=0.
- Back-to-back: start with 12'h045, then start in its done cycle with 12'h310 → done pulses 11 clocks apart, bin_out=45 then 310. A start pulse mid-CONV is ignored and the result is unchanged.
- rst_n low for 1 cycle at CONV iteration 5 → all outputs 0, no done. The next start with 12'h001 gives bin_out=1 after 10 clocks.
- 12'h2A7 with BCD2BIN_CHECK_EN → done 1 clock after start, err=1, bin_out=0. Without the macro → 10-clock latency, err=0.
